// File: rtl/stack_ctrl_pkg.sv
// rtl/stack_ctrl_pkg.sv - shared opcodes, state encoding and slot size for the stack sequencer
// Optional macro STACK_BOUNDS_CHECK_EN adds the FAULT state.
package stack_ctrl_pkg;

  localparam int unsigned SP_STEP_DEFAULT = 4;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SP_RD = 3'd1,
    ST_MEM   = 3'd2,
`ifdef STACK_BOUNDS_CHECK_EN
    ST_WB    = 3'd3,
    ST_FAULT = 3'd4
`else
    ST_WB    = 3'd3
`endif
  } state_e;

  // PUSH and CALL grow the stack downwards; POP and RET shrink it.
  function automatic logic is_store(input op_e op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/stack_addr_gen.sv
// rtl/stack_addr_gen.sv - combinational stack address, next-SP and bounds compare
module stack_addr_gen
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          SP_STEP     = SP_STEP_DEFAULT,
  parameter logic [DATA_W-1:0]    STACK_LIMIT = 32'h0000_0800,
  parameter logic [DATA_W-1:0]    STACK_TOP   = 32'h0000_1000
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] sp,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] sp_next,
  output logic              fault
);

  logic [DATA_W-1:0] sp_dec;
  logic [DATA_W-1:0] sp_inc;

  assign sp_dec = sp - DATA_W'(SP_STEP);
  assign sp_inc = sp + DATA_W'(SP_STEP);

  // Stores pre-decrement; loads read at the current SP then post-increment.
  assign mem_addr = is_store(op) ? sp_dec : sp;
  assign sp_next  = is_store(op) ? sp_dec : sp_inc;
  assign fault    = is_store(op) ? (sp_dec < STACK_LIMIT) : (sp >= STACK_TOP);

endmodule

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - PUSH/POP/CALL/RET sequencer over register-bank SP port and data memory
// Optional macro STACK_BOUNDS_CHECK_EN enables overflow/underflow faults.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       SP_STEP     = SP_STEP_DEFAULT,
  parameter logic [DATA_W-1:0] STACK_LIMIT = 32'h0000_0800,
  parameter logic [DATA_W-1:0] STACK_TOP   = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [DATA_W-1:0] op_data,
  input  logic [DATA_W-1:0] op_target,
  input  logic [4:0]        op_dr,
  output logic              readSP,
  input  logic [DATA_W-1:0] sp_rdata,
  output logic              writeSP,
  output logic [DATA_W-1:0] write_dataSP,
  output logic              writeReg,
  output logic [4:0]        dr,
  output logic [DATA_W-1:0] write_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_value,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [4:0]        dr_q, dr_d;
  logic [DATA_W-1:0] sp_q, sp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] ag_sp;
  logic [DATA_W-1:0] ag_addr;
  logic [DATA_W-1:0] ag_sp_next;
  logic              bounds_fault;

  // The bounds compare must see the SP being read this cycle, not the stale copy.
  assign ag_sp = (state_q == ST_SP_RD) ? sp_rdata : sp_q;

  stack_addr_gen #(
    .DATA_W      (DATA_W),
    .SP_STEP     (SP_STEP),
    .STACK_LIMIT (STACK_LIMIT),
    .STACK_TOP   (STACK_TOP)
  ) u_addr_gen (
    .op       (op_q),
    .sp       (ag_sp),
    .mem_addr (ag_addr),
    .sp_next  (ag_sp_next),
    .fault    (bounds_fault)
  );

`ifndef STACK_BOUNDS_CHECK_EN
  logic unused_bounds_fault;
  assign unused_bounds_fault = bounds_fault;
`endif

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    data_d       = data_q;
    target_d     = target_q;
    dr_d         = dr_q;
    sp_d         = sp_q;
    rdata_d      = rdata_q;
    op_ready     = 1'b0;
    readSP       = 1'b0;
    writeSP      = 1'b0;
    write_dataSP = '0;
    writeReg     = 1'b0;
    dr           = '0;
    write_data   = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    pc_load      = 1'b0;
    pc_value     = '0;
    done         = 1'b0;
    err          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          op_d     = op_e'(op_code);
          data_d   = op_data;
          target_d = op_target;
          dr_d     = op_dr;
          state_d  = ST_SP_RD;
        end
      end
      ST_SP_RD: begin
        readSP  = 1'b1;
        sp_d    = sp_rdata;
`ifdef STACK_BOUNDS_CHECK_EN
        state_d = bounds_fault ? ST_FAULT : ST_MEM;
`else
        state_d = ST_MEM;
`endif
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        mem_we    = is_store(op_q);
        mem_addr  = ag_addr;
        mem_wdata = data_q;
        if (mem_ack) begin
          if (!is_store(op_q)) rdata_d = mem_rdata;
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        writeSP      = 1'b1;
        write_dataSP = ag_sp_next;
        done         = 1'b1;
        state_d      = ST_IDLE;
        case (op_q)
          OP_POP: begin
            writeReg   = 1'b1;
            dr         = dr_q;
            write_data = rdata_q;
          end
          OP_CALL: begin
            pc_load  = 1'b1;
            pc_value = target_q;
          end
          OP_RET: begin
            pc_load  = 1'b1;
            pc_value = rdata_q;
          end
          default: ;
        endcase
      end
`ifdef STACK_BOUNDS_CHECK_EN
      ST_FAULT: begin
        err     = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_PUSH;
      data_q   <= '0;
      target_q <= '0;
      dr_q     <= '0;
      sp_q     <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      target_q <= target_d;
      dr_q     <= dr_d;
      sp_q     <= sp_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - directed self-checking bench for stack_ctrl (optional macro STACK_BOUNDS_CHECK_EN)
module tb_stack_ctrl;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_code;
  logic [31:0] op_data;
  logic [31:0] op_target;
  logic [4:0]  op_dr;
  logic        readSP;
  logic [31:0] sp_rdata;
  logic        writeSP;
  logic [31:0] write_dataSP;
  logic        writeReg;
  logic [4:0]  dr;
  logic [31:0] write_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        pc_load;
  logic [31:0] pc_value;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  stack_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_code      (op_code),
    .op_data      (op_data),
    .op_target    (op_target),
    .op_dr        (op_dr),
    .readSP       (readSP),
    .sp_rdata     (sp_rdata),
    .writeSP      (writeSP),
    .write_dataSP (write_dataSP),
    .writeReg     (writeReg),
    .dr           (dr),
    .write_data   (write_data),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .pc_load      (pc_load),
    .pc_value     (pc_value),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the request for one edge; returns in cycle T+1 (SP_RD).
  task automatic issue(input logic [1:0] code, input logic [31:0] data,
                       input logic [31:0] target, input logic [4:0] rd);
    op_valid  = 1'b1;
    op_code   = code;
    op_data   = data;
    op_target = target;
    op_dr     = rd;
    step();
    op_valid  = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({readSP, writeSP, writeReg, mem_req, mem_we, pc_load, done, err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_strobes got %b exp 00000000",
               {readSP, writeSP, writeReg, mem_req, mem_we, pc_load, done, err});
    end
    checks++;
    if ({dr, write_dataSP, write_data, mem_addr, mem_wdata, pc_value} !== '0) begin
      errors++;
      $display("FAIL reset_data got dr=%h wsp=%h wd=%h ma=%h mw=%h pc=%h exp all 0",
               dr, write_dataSP, write_data, mem_addr, mem_wdata, pc_value);
    end
    step();
    reset = 1'b1;
    step();
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_op_ready got %b exp 1", op_ready);
    end
  endtask

  task automatic test_push();
    issue(2'b00, 32'hDEAD_BEEF, 32'h0, 5'd0);
    checks++;
    if ({readSP, op_ready} !== 2'b10) begin
      errors++;
      $display("FAIL push_sp_rd got readSP/op_ready=%b exp 10", {readSP, op_ready});
    end
    sp_rdata = 32'h0000_1000;
    step();
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h0000_0FFC, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL push_mem got req=%b we=%b addr=%h wdata=%h exp 1 1 00000ffc deadbeef",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++;
    if ({writeSP, write_dataSP, done, writeReg, pc_load, err} !== {1'b1, 32'h0000_0FFC, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL push_wb got wsp=%b sp=%h done=%b wreg=%b pcl=%b err=%b exp 1 00000ffc 1 0 0 0",
               writeSP, write_dataSP, done, writeReg, pc_load, err);
    end
    step();
    checks++;
    if ({op_ready, done, writeSP} !== 3'b100) begin
      errors++;
      $display("FAIL push_idle got ready/done/wsp=%b exp 100", {op_ready, done, writeSP});
    end
  endtask

  task automatic test_pop(input logic [4:0] rd);
    issue(2'b01, 32'h0, 32'h0, rd);
    sp_rdata = 32'h0000_0FFC;
    step();
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0000_0FFC}) begin
      errors++;
      $display("FAIL pop_mem dr%0d got req=%b we=%b addr=%h exp 1 0 00000ffc", rd, mem_req, mem_we, mem_addr);
    end
    mem_rdata = 32'hDEAD_BEEF;
    mem_ack   = 1'b1;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    checks++;
    if ({writeSP, write_dataSP, writeReg, dr, write_data, pc_load, done}
        !== {1'b1, 32'h0000_1000, 1'b1, rd, 32'hDEAD_BEEF, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL pop_wb dr%0d got wsp=%b sp=%h wreg=%b dr=%0d wd=%h pcl=%b done=%b exp 1 00001000 1 %0d deadbeef 0 1",
               rd, writeSP, write_dataSP, writeReg, dr, write_data, pc_load, done, rd);
    end
    step();
  endtask

  task automatic test_call_ret();
    issue(2'b10, 32'h0000_0104, 32'h0000_0400, 5'd0);
    sp_rdata = 32'h0000_1000;
    step();
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h0000_0FFC, 32'h0000_0104}) begin
      errors++;
      $display("FAIL call_mem got req=%b we=%b addr=%h wdata=%h exp 1 1 00000ffc 00000104",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++;
    if ({writeSP, write_dataSP, pc_load, pc_value, writeReg, done}
        !== {1'b1, 32'h0000_0FFC, 1'b1, 32'h0000_0400, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL call_wb got wsp=%b sp=%h pcl=%b pc=%h wreg=%b done=%b exp 1 00000ffc 1 00000400 0 1",
               writeSP, write_dataSP, pc_load, pc_value, writeReg, done);
    end
    step();
    issue(2'b11, 32'h0, 32'h0, 5'd0);
    sp_rdata = 32'h0000_0FFC;
    step();
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0000_0FFC}) begin
      errors++;
      $display("FAIL ret_mem got req=%b we=%b addr=%h exp 1 0 00000ffc", mem_req, mem_we, mem_addr);
    end
    mem_rdata = 32'h0000_0104;
    mem_ack   = 1'b1;
    step();
    mem_ack   = 1'b0;
    checks++;
    if ({writeSP, write_dataSP, pc_load, pc_value, writeReg, done}
        !== {1'b1, 32'h0000_1000, 1'b1, 32'h0000_0104, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ret_wb got wsp=%b sp=%h pcl=%b pc=%h wreg=%b done=%b exp 1 00001000 1 00000104 0 1",
               writeSP, write_dataSP, pc_load, pc_value, writeReg, done);
    end
    step();
  endtask

  task automatic test_back_to_back();
    issue(2'b00, 32'h1122_3344, 32'h0, 5'd0);
    sp_rdata = 32'h0000_1000;
    step();
    // MEM cycles T+2..T+4 without ack, decode keeps pushing a POP request.
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, op_ready, done}
          !== {1'b1, 1'b1, 32'h0000_0FFC, 32'h1122_3344, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL wait_mem%0d got req=%b we=%b addr=%h wdata=%h ready=%b done=%b exp 1 1 00000ffc 11223344 0 0",
                 i, mem_req, mem_we, mem_addr, mem_wdata, op_ready, done);
      end
      op_valid = 1'b1;
      op_code  = 2'b01;
      if (i == 3) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    checks++;
    if ({done, writeSP, write_dataSP, writeReg, op_ready} !== {1'b1, 1'b1, 32'h0000_0FFC, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wait_wb got done=%b wsp=%b sp=%h wreg=%b ready=%b exp 1 1 00000ffc 0 0",
               done, writeSP, write_dataSP, writeReg, op_ready);
    end
    step();
    checks++;
    if ({op_ready, readSP, done} !== 3'b100) begin
      errors++;
      $display("FAIL wait_after_done got ready/readSP/done=%b exp 100", {op_ready, readSP, done});
    end
    op_valid = 1'b0;
    step();
    checks++;
    if ({op_ready, readSP} !== 2'b10) begin
      errors++;
      $display("FAIL wait_idle got ready/readSP=%b exp 10", {op_ready, readSP});
    end
  endtask

  task automatic test_reset_mid_op();
    issue(2'b00, 32'hCAFE_F00D, 32'h0, 5'd0);
    sp_rdata = 32'h0000_1000;
    step();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre got mem_req=%b exp 1", mem_req);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({readSP, writeSP, writeReg, mem_req, mem_we, pc_load, done, err} !== 8'h00) begin
      errors++;
      $display("FAIL abort_async got strobes=%b exp 00000000",
               {readSP, writeSP, writeReg, mem_req, mem_we, pc_load, done, err});
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    reset   = 1'b1;
    step();
    checks++;
    if ({op_ready, writeSP, readSP, mem_req} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_release got ready/wsp/readSP/req=%b exp 1000",
               {op_ready, writeSP, readSP, mem_req});
    end
  endtask

  task automatic test_bounds();
`ifdef STACK_BOUNDS_CHECK_EN
    issue(2'b00, 32'h5555_AAAA, 32'h0, 5'd0);
    sp_rdata = 32'h0000_0800;
    step();
    checks++;
    if ({err, done, mem_req, writeSP, writeReg, pc_load} !== 6'b110000) begin
      errors++;
      $display("FAIL bounds_push got err/done/req/wsp/wreg/pcl=%b exp 110000",
               {err, done, mem_req, writeSP, writeReg, pc_load});
    end
    step();
    issue(2'b01, 32'h0, 32'h0, 5'd3);
    sp_rdata = 32'h0000_1000;
    step();
    checks++;
    if ({err, done, mem_req, writeSP, writeReg, pc_load} !== 6'b110000) begin
      errors++;
      $display("FAIL bounds_pop got err/done/req/wsp/wreg/pcl=%b exp 110000",
               {err, done, mem_req, writeSP, writeReg, pc_load});
    end
    step();
    checks++;
    if ({op_ready, err, done} !== 3'b100) begin
      errors++;
      $display("FAIL bounds_idle got ready/err/done=%b exp 100", {op_ready, err, done});
    end
`else
    issue(2'b00, 32'h5555_AAAA, 32'h0, 5'd0);
    sp_rdata = 32'h0000_0800;
    step();
    checks++;
    if ({mem_req, mem_addr, err} !== {1'b1, 32'h0000_07FC, 1'b0}) begin
      errors++;
      $display("FAIL nobounds_mem got req=%b addr=%h err=%b exp 1 000007fc 0", mem_req, mem_addr, err);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++;
    if ({writeSP, write_dataSP, done, err} !== {1'b1, 32'h0000_07FC, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL nobounds_wb got wsp=%b sp=%h done=%b err=%b exp 1 000007fc 1 0",
               writeSP, write_dataSP, done, err);
    end
    step();
`endif
  endtask

  initial begin
    reset     = 1'b0;
    op_valid  = 1'b0;
    op_code   = 2'b00;
    op_data   = '0;
    op_target = '0;
    op_dr     = '0;
    sp_rdata  = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    test_reset();
    test_push();
    test_pop(5'd5);
    test_pop(5'd0);
    test_call_ret();
    test_back_to_back();
    test_reset_mid_op();
    test_bounds();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
Stack sequencer that drives the SP and register-write ports of the register bank and the data-memory port, executing PUSH, POP, CALL and RET as multi-cycle operations. It reads SP through the bank's SP read path, performs one memory access, then writes back the updated SP plus either a destination register (POP) or a PC load (CALL/RET). It sits between instruction decode and the register bank / data memory.

Parameters:
DATA_W, 32, datapath and address width
SP_STEP, 4, bytes per stack slot
STACK_LIMIT, 32'h0000_0800, lowest legal SP; used only with the optional feature
STACK_TOP, 32'h0000_1000, highest legal SP (empty stack); used only with the optional feature

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset asserted
op_valid  in  1  request strobe from decode
op_ready  out  1  block can accept a request
op_code  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET
op_data  in  DATA_W  PUSH: value to store; CALL: return address
op_target  in  DATA_W  CALL: jump target
op_dr  in  5  POP destination register
readSP  out  1  selects SP onto bank read_data1
sp_rdata  in  DATA_W  bank read_data1
writeSP  out  1  SP write strobe
write_dataSP  out  DATA_W  new SP value
writeReg  out  1  register write strobe (POP only)
dr  out  5  destination register
write_data  out  DATA_W  popped value
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write
mem_addr  out  DATA_W  byte address
mem_wdata  out  DATA_W  store data
mem_rdata  in  DATA_W  load data, valid with mem_ack
mem_ack  in  1  access complete
pc_load  out  1  one-cycle PC load strobe (CALL/RET)
pc_value  out  DATA_W  PC to load
done  out  1  one-cycle completion pulse
err  out  1  bounds fault pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (reset=0, async): state IDLE; all strobes (readSP, writeSP, writeReg, mem_req, mem_we, pc_load, done, err) 0; all data outputs and dr 0; op_ready 1 after release.
- States: IDLE -> SP_RD -> MEM -> WB -> IDLE.
- IDLE: op_ready=1. On op_valid, latch op_code/op_data/op_target/op_dr; next SP_RD. op_ready=0 in all other states.
- SP_RD (1 cycle): readSP=1; capture sp_rdata at end of cycle.
- MEM: mem_req=1, address/data stable until mem_ack; stay while mem_ack=0.
  PUSH/CALL: mem_we=1, mem_addr=sp-SP_STEP, mem_wdata=op_data (CALL stores its return address). POP/RET: mem_we=0, mem_addr=sp; mem_rdata captured on mem_ack.
- WB (1 cycle): writeSP=1; write_dataSP=sp-SP_STEP (PUSH/CALL) or sp+SP_STEP (POP/RET), modulo 2^DATA_W wrap.
  POP: writeReg=1, dr=op_dr, write_data=loaded value. CALL: pc_load=1, pc_value=op_target. RET: pc_load=1, pc_value=loaded value. done=1. Next IDLE.
- Latency: with mem_ack on the first MEM cycle, accept at T, done at T+3; each wait cycle adds one.
- Strobes are 1 only in the states listed; data outputs may hold stale values when their strobe is 0.
- Simultaneous op_valid and done: the new request is not accepted until the following IDLE cycle.
- Reset mid-operation aborts immediately: mem_req drops, and no SP, register or PC write occurs.
- POP with op_dr=0 still issues writeReg; the bank ignores it.

Optional Feature:
STACK_BOUNDS_CHECK_EN: when defined, SP_RD checks PUSH/CALL with sp-SP_STEP < STACK_LIMIT (overflow) and POP/RET with sp >= STACK_TOP (underflow). On a fault, the next cycle is a single FAULT state: err=1, done=1, no memory access, no SP/register/PC write, then IDLE. When undefined, there is no check and no FAULT state, and err is constant 0.

Decomposition:
- Shared package: op_code encodings (OP_PUSH/OP_POP/OP_CALL/OP_RET), state enum, SP_STEP default.
- One sub-module, stack_addr_gen: computes mem_addr, next SP and the bounds compare. It is combinational; all sequencing stays in stack_ctrl.

Test Plan:
- sp_rdata=0x1000, PUSH op_data=0xDEADBEEF, mem_ack immediate -> write at addr 0xFFC with 0xDEADBEEF; write_dataSP=0xFFC; done at T+3.
- sp_rdata=0xFFC, POP op_dr=5, mem_rdata=0xDEADBEEF -> read addr 0xFFC; writeReg with dr=5 and data 0xDEADBEEF; write_dataSP=0x1000.
- CALL op_data=0x104 op_target=0x400 at SP 0x1000, then RET at SP 0xFFC -> store 0x104 at 0xFFC; pc_value=0x400, then pc_value=0x104; SP ends at 0x1000.
- mem_ack delayed 3 cycles -> mem_req and mem_addr held steady; done at T+6; op_valid during busy is ignored.
- reset pulled low during MEM -> all strobes 0 asynchronously; writeSP never asserted; op_ready=1 after release.
- With STACK_BOUNDS_CHECK_EN: PUSH at SP 0x800 -> err=1, done=1, no mem_req, no writeSP; POP at SP 0x1000 -> same.
